// File: rtl/core_pkg.sv
// Shared opcode encodings, control-bundle type and multiplier FSM states for
// the 16-bit core's decode/issue stage.
package core_pkg;

  localparam logic [6:0] OP_ADD  = 7'b0000000;
  localparam logic [6:0] OP_SUB  = 7'b0000001;
  localparam logic [6:0] OP_MOV  = 7'b0000010;
  localparam logic [6:0] OP_XSR  = 7'b0000011;
  localparam logic [6:0] OP_LCG  = 7'b0000100;
  localparam logic [6:0] OP_LDR  = 7'b0000101;
  localparam logic [6:0] OP_STR  = 7'b0000110;
  localparam logic [6:0] OP_BIT  = 7'b0000111;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_SUBI = 6'b000101;
  localparam logic [2:0] OP_LDA  = 3'b010;

  localparam logic [1:0] CC_ZERO  = 2'b00;
  localparam logic [1:0] CC_ONE   = 2'b01;
  localparam logic [1:0] CC_RSMSB = 2'b10;
  localparam logic [1:0] CC_CARRY = 2'b11;

  typedef struct packed {
    logic invert;
    logic carry_en;
    logic carry_in;
    logic addload;
    logic aluread;
    logic addmov;
    logic xsr_sel;
    logic bit_sel;
    logic reg_imm;
    logic reg_offset;
  } issue_ctl_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } mul_state_e;

  function automatic issue_ctl_t decode_ctl(input logic [15:0] instr,
                                            input logic       rs_msb,
                                            input logic       carry_status);
    logic [6:0] op;
    logic add, sub, mov, xsr, lcg, ldr, str, bitop, addi, subi, lda, known;
    logic cin;
    issue_ctl_t c;
    op    = instr[15:9];
    add   = (op == OP_ADD);
    sub   = (op == OP_SUB);
    mov   = (op == OP_MOV);
    xsr   = (op == OP_XSR);
    lcg   = (op == OP_LCG);
    ldr   = (op == OP_LDR);
    str   = (op == OP_STR);
    bitop = (op == OP_BIT);
    addi  = (op[6:1] == OP_ADDI);
    subi  = (op[6:1] == OP_SUBI);
    lda   = (op[6:4] == OP_LDA);
    known = add | sub | mov | xsr | lcg | ldr | str | bitop | addi | subi | lda;
    case (instr[8:7])
      CC_ZERO:  cin = 1'b0;
      CC_ONE:   cin = 1'b1;
      CC_RSMSB: cin = rs_msb;
      default:  cin = carry_status;
    endcase
    if (ldr | str)       cin = 1'b0;
    else if (subi | lcg) cin = 1'b1;
    c            = '0;
    c.invert     = sub | subi | lcg;
    c.carry_en   = instr[6] & (add | sub | mov | xsr | addi | subi);
    c.carry_in   = known & cin;
    c.addload    = add | sub | mov | xsr | bitop | addi | subi | lcg;
    // Unrecognised opcodes must decode to an all-zero bundle, so aluread is gated.
    c.aluread    = known & ~(c.addload | ldr | str);
    c.addmov     = mov;
    c.xsr_sel    = xsr;
    c.bit_sel    = bitop;
    c.reg_imm    = addi | subi | ldr | str | lcg;
    c.reg_offset = ldr | str;
    return c;
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch-side handshake plus issued control bundle of the decode/issue stage.
interface decode_issue_stage_if #(
  parameter int DW  = 16,
  parameter int RAW = 3
);
  logic           instr_valid;
  logic [15:0]    instr;
  logic [RAW-1:0] rd;
  logic [RAW-1:0] rs;
  logic           carry_status;
  logic           rs_msb;
  logic           instr_ready;
  logic           ctl_valid;
  logic           invert, carry_en, carry_in, addload, aluread;
  logic           addmov, xsr_sel, bit_sel, reg_imm, reg_offset;
  logic [DW-1:0]  imm;
  logic [RAW-1:0] rd_q;
  logic [RAW-1:0] rs_q;
  logic           rd_from_ram, rs_from_ram;
  logic           mul_start, mul_last, mul_busy, mul_loop, mul_msb, mul_gp5;

  modport master (
    output instr_valid, instr, rd, rs, carry_status, rs_msb,
    input  instr_ready, ctl_valid, invert, carry_en, carry_in, addload, aluread,
           addmov, xsr_sel, bit_sel, reg_imm, reg_offset, imm, rd_q, rs_q,
           rd_from_ram, rs_from_ram,
           mul_start, mul_last, mul_busy, mul_loop, mul_msb, mul_gp5
  );

  modport slave (
    input  instr_valid, instr, rd, rs, carry_status, rs_msb,
    output instr_ready, ctl_valid, invert, carry_en, carry_in, addload, aluread,
           addmov, xsr_sel, bit_sel, reg_imm, reg_offset, imm, rd_q, rs_q,
           rd_from_ram, rs_from_ram,
           mul_start, mul_last, mul_busy, mul_loop, mul_msb, mul_gp5
  );
endinterface

// File: rtl/load_scoreboard.sv
// In-flight load tracker: LOAD_LAT-deep shift register of {valid, reg}; entry 0
// is the youngest, entry LOAD_LAT-1 the oldest (its data is on the RAM port).
module load_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int RAW      = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [RAW-1:0] push_reg_i,
  input  logic [RAW-1:0] rd_i,
  input  logic [RAW-1:0] rs_i,
  output logic           match_oldest_rd,
  output logic           match_oldest_rs,
  output logic           match_young
);

  logic [LOAD_LAT-1:0] vld_q;
  logic [RAW-1:0]      reg_q [LOAD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LOAD_LAT; i++) reg_q[i] <= '0;
    end else begin
      vld_q[0] <= push_i;
      reg_q[0] <= push_i ? push_reg_i : '0;
      for (int unsigned i = 1; i < LOAD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        reg_q[i] <= reg_q[i-1];
      end
    end
  end

  assign match_oldest_rd = vld_q[LOAD_LAT-1] & (reg_q[LOAD_LAT-1] == rd_i);
  assign match_oldest_rs = vld_q[LOAD_LAT-1] & (reg_q[LOAD_LAT-1] == rs_i);

  always_comb begin
    match_young = 1'b0;
    for (int unsigned i = 0; i + 1 < LOAD_LAT; i++) begin
      if (vld_q[i] && ((reg_q[i] == rd_i) || (reg_q[i] == rs_i))) match_young = 1'b1;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage: control bundle, load interlock and LCG
// multiplier sequencing. Define DECODE_LOAD_FWD_EN to forward from RAM.
module decode_issue_stage
  import core_pkg::*;
#(
  parameter int DW         = 16,
  parameter int RAW        = 3,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_issue_stage_if.slave bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           gp5_q, gp5_d, loop_q, loop_d, msb_q, msb_d, start_q, start_d;
  logic           valid_q, valid_d;
  issue_ctl_t     ctl_q, ctl_d, dec;
  logic [DW-1:0]  imm_q, imm_d, imm_dec;
  logic [RAW-1:0] rdr_q, rdr_d, rsr_q, rsr_d;
  logic           rdf_q, rdf_d, rsf_q, rsf_d;
  logic           m_old_rd, m_old_rs, m_young, hazard, ready, accept;
  logic           is_lcg, is_load;
  logic [6:0]     op;
  logic           unused_bits;

  assign op          = bus.instr[15:9];
  assign unused_bits = ^bus.instr[2:0];
  assign dec         = decode_ctl(bus.instr, bus.rs_msb, bus.carry_status);
  assign is_lcg      = (op == OP_LCG);
  assign is_load     = (op == OP_LDR) || (op[6:4] == OP_LDA);

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .RAW      (RAW)
  ) u_sb (
    .clk             (clk),
    .rst_n           (rst_n),
    .push_i          (accept & is_load),
    .push_reg_i      (bus.rd),
    .rd_i            (bus.rd),
    .rs_i            (bus.rs),
    .match_oldest_rd (m_old_rd),
    .match_oldest_rs (m_old_rs),
    .match_young     (m_young)
  );

`ifdef DECODE_LOAD_FWD_EN
  assign hazard = m_young;
`else
  assign hazard = m_young | m_old_rd | m_old_rs;
`endif

  assign ready  = (state_q == ST_IDLE) & ~hazard;
  assign accept = bus.instr_valid & ready;

  always_comb begin
    imm_dec = '0;
    if (op[6:1] == OP_ADDI || op[6:1] == OP_SUBI) imm_dec = DW'(bus.instr[9:3]);
    else if (op == OP_LDR || op == OP_STR)        imm_dec = DW'(bus.instr[8:6]);
    else if (op == OP_LCG)                        imm_dec = DW'(1);
  end

  always_comb begin
    valid_d = 1'b0;
    ctl_d   = '0;
    imm_d   = '0;
    rdr_d   = '0;
    rsr_d   = '0;
    rdf_d   = 1'b0;
    rsf_d   = 1'b0;
    start_d = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    gp5_d   = gp5_q;
    loop_d  = loop_q;
    msb_d   = msb_q;
    if (accept) begin
      valid_d = 1'b1;
      ctl_d   = dec;
      imm_d   = imm_dec;
      rdr_d   = bus.rd;
      rsr_d   = bus.rs;
`ifdef DECODE_LOAD_FWD_EN
      rdf_d   = m_old_rd;
      rsf_d   = m_old_rs;
`endif
    end
    case (state_q)
      ST_IDLE: begin
        if (accept && is_lcg) begin
          state_d = ST_MUL;
          cnt_d   = CW'(MUL_CYCLES - 1);
          start_d = 1'b1;
          gp5_d   = ~bus.instr[8];
          loop_d  = bus.instr[7];
          msb_d   = bus.instr[6];
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gp5_d   = 1'b0;
          loop_d  = 1'b0;
          msb_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gp5_q   <= 1'b0;
      loop_q  <= 1'b0;
      msb_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ctl_q   <= '0;
      imm_q   <= '0;
      rdr_q   <= '0;
      rsr_q   <= '0;
      rdf_q   <= 1'b0;
      rsf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gp5_q   <= gp5_d;
      loop_q  <= loop_d;
      msb_q   <= msb_d;
      start_q <= start_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      imm_q   <= imm_d;
      rdr_q   <= rdr_d;
      rsr_q   <= rsr_d;
      rdf_q   <= rdf_d;
      rsf_q   <= rsf_d;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.ctl_valid   = valid_q;
  assign bus.invert      = ctl_q.invert;
  assign bus.carry_en    = ctl_q.carry_en;
  assign bus.carry_in    = ctl_q.carry_in;
  assign bus.addload     = ctl_q.addload;
  assign bus.aluread     = ctl_q.aluread;
  assign bus.addmov      = ctl_q.addmov;
  assign bus.xsr_sel     = ctl_q.xsr_sel;
  assign bus.bit_sel     = ctl_q.bit_sel;
  assign bus.reg_imm     = ctl_q.reg_imm;
  assign bus.reg_offset  = ctl_q.reg_offset;
  assign bus.imm         = imm_q;
  assign bus.rd_q        = rdr_q;
  assign bus.rs_q        = rsr_q;
  assign bus.rd_from_ram = rdf_q;
  assign bus.rs_from_ram = rsf_q;
  assign bus.mul_start   = start_q;
  assign bus.mul_busy    = (state_q == ST_MUL);
  assign bus.mul_last    = (state_q == ST_MUL) && (cnt_q == '0);
  assign bus.mul_gp5     = gp5_q;
  assign bus.mul_loop    = loop_q;
  assign bus.mul_msb     = msb_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: one instance with LOAD_LAT=1 and one
// with LOAD_LAT=3; expectations follow DECODE_LOAD_FWD_EN.
module tb_decode_issue_stage;
  import core_pkg::*;

`ifdef DECODE_LOAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_issue_stage_if #(.DW(16), .RAW(3)) if1 ();
  decode_issue_stage_if #(.DW(16), .RAW(3)) if3 ();

  decode_issue_stage #(.DW(16), .RAW(3), .LOAD_LAT(1), .MUL_CYCLES(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  decode_issue_stage #(.DW(16), .RAW(3), .LOAD_LAT(3), .MUL_CYCLES(16)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic [10:0] ctl1, ctl3;
  logic [40:0] all1, all3;
  assign ctl1 = {if1.ctl_valid, if1.invert, if1.carry_en, if1.carry_in, if1.addload,
                 if1.aluread, if1.addmov, if1.xsr_sel, if1.bit_sel, if1.reg_imm, if1.reg_offset};
  assign ctl3 = {if3.ctl_valid, if3.invert, if3.carry_en, if3.carry_in, if3.addload,
                 if3.aluread, if3.addmov, if3.xsr_sel, if3.bit_sel, if3.reg_imm, if3.reg_offset};
  assign all1 = {ctl1, if1.imm, if1.rd_q, if1.rs_q, if1.rd_from_ram, if1.rs_from_ram,
                 if1.mul_start, if1.mul_last, if1.mul_busy, if1.mul_loop, if1.mul_msb, if1.mul_gp5};
  assign all3 = {ctl3, if3.imm, if3.rd_q, if3.rs_q, if3.rd_from_ram, if3.rs_from_ram,
                 if3.mul_start, if3.mul_last, if3.mul_busy, if3.mul_loop, if3.mul_msb, if3.mul_gp5};

  logic [15:0] vi [9];
  logic [10:0] vc [9];
  logic [15:0] vm [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if1.instr_valid = 1'b0; if1.instr = '0; if1.rd = '0; if1.rs = '0;
    if1.carry_status = 1'b1; if1.rs_msb = 1'b0;
    if3.instr_valid = 1'b0; if3.instr = '0; if3.rd = '0; if3.rs = '0;
    if3.carry_status = 1'b0; if3.rs_msb = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (all1 !== '0) begin failures++; $display("FAIL reset_out_l1 got=%h exp=0", all1); end
    checks++; if (all3 !== '0) begin failures++; $display("FAIL reset_out_l3 got=%h exp=0", all3); end
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_l1 got=%b exp=1", if1.instr_ready); end
    checks++; if (if3.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_l3 got=%b exp=1", if3.instr_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    // ctl order: valid invert carry_en carry_in addload aluread addmov xsr bit reg_imm reg_offset
    vi = '{{OP_ADD, 2'b11, 1'b1, 6'd0}, {OP_SUB, 2'b10, 1'b1, 6'd0}, {OP_MOV, 2'b01, 1'b0, 6'd0},
           {OP_XSR, 2'b00, 1'b1, 6'd0}, {OP_BIT, 2'b11, 1'b1, 6'd0}, {OP_SUBI, 7'h55, 3'd0},
           {OP_ADDI, 7'h2A, 3'd0}, {OP_STR, 3'b110, 6'd0}, {7'b1111111, 2'b11, 1'b1, 6'd0}};
    vc = '{11'b10111000000, 11'b11101000000, 11'b10011010000,
           11'b10101001000, 11'b10011000100, 11'b11011000010,
           11'b10101000010, 11'b10000000011, 11'b10000000000};
    vm = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0055,
           16'h002A, 16'h0006, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      if1.instr = vi[i]; if1.rd = 3'(i); if1.rs = 3'(7 - i); if1.instr_valid = 1'b1;
      tick();
      checks++; if (ctl1 !== vc[i]) begin failures++; $display("FAIL decode_ctl[%0d] got=%b exp=%b", i, ctl1, vc[i]); end
      checks++; if (if1.imm !== vm[i]) begin failures++; $display("FAIL decode_imm[%0d] got=%h exp=%h", i, if1.imm, vm[i]); end
      checks++; if ({if1.rd_q, if1.rs_q} !== {3'(i), 3'(7 - i)}) begin
        failures++; $display("FAIL decode_regs[%0d] got=%b exp=%b", i, {if1.rd_q, if1.rs_q}, {3'(i), 3'(7 - i)}); end
    end
    if1.instr_valid = 1'b0;
    tick();
    checks++; if (ctl1 !== '0) begin failures++; $display("FAIL bubble_ctl got=%b exp=0", ctl1); end
  endtask

  task automatic test_load_fwd_l1();
    int stalls = 0;
    if1.instr = {OP_LDR, 3'b101, 6'd0}; if1.rd = 3'd3; if1.rs = 3'd0; if1.instr_valid = 1'b1;
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL l1_ldr_ready got=%b exp=1", if1.instr_ready); end
    tick();
    if1.instr = {OP_ADD, 2'b00, 1'b0, 6'd0}; if1.rd = 3'd1; if1.rs = 3'd3;
    checks++; if (ctl1 !== 11'b10000000011 || if1.imm !== 16'h0005 || if1.rd_q !== 3'd3) begin
      failures++; $display("FAIL l1_ldr_bundle got=%b/%h/%0d exp=10000000011/0005/3", ctl1, if1.imm, if1.rd_q); end
    #1;
    while (!if1.instr_ready && stalls < 8) begin tick(); stalls++; end
    checks++; if (stalls != (FWD ? 0 : 1)) begin failures++; $display("FAIL l1_stalls got=%0d exp=%0d", stalls, FWD ? 0 : 1); end
    tick();
    if1.instr_valid = 1'b0;
    checks++; if ({if1.ctl_valid, if1.addload, if1.rs_q, if1.rd_from_ram, if1.rs_from_ram} !== {2'b11, 3'd3, 1'b0, FWD}) begin
      failures++; $display("FAIL l1_use_bundle got=%b exp=%b",
        {if1.ctl_valid, if1.addload, if1.rs_q, if1.rd_from_ram, if1.rs_from_ram}, {2'b11, 3'd3, 1'b0, FWD}); end
    repeat (2) tick();
  endtask

  task automatic test_load_hazard_l3(input bit gap, input logic [2:0] lreg,
                                     input logic [2:0] urd, input logic [2:0] urs, input int exp_st);
    int stalls = 0;
    int bub_bad = 0;
    if3.instr = {OP_LDR, 3'b001, 6'd0}; if3.rd = lreg; if3.rs = 3'd0; if3.instr_valid = 1'b1;
    tick();
    if (gap) begin if3.instr_valid = 1'b0; tick(); end
    if3.instr = {OP_MOV, 2'b00, 1'b0, 6'd0}; if3.rd = urd; if3.rs = urs; if3.instr_valid = 1'b1;
    #1;
    while (!if3.instr_ready && stalls < 8) begin
      tick(); stalls++;
      if (if3.ctl_valid !== 1'b0) bub_bad++;
    end
    checks++; if (stalls != exp_st) begin failures++; $display("FAIL l3_stalls gap=%0d got=%0d exp=%0d", gap, stalls, exp_st); end
    checks++; if (bub_bad != 0) begin failures++; $display("FAIL l3_bubble gap=%0d got=%0d exp=0", gap, bub_bad); end
    tick();
    if3.instr_valid = 1'b0;
    checks++; if ({if3.ctl_valid, if3.addmov, if3.rd_q, if3.rd_from_ram, if3.rs_from_ram}
                  !== {2'b11, urd, FWD & (urd == lreg), FWD & (urs == lreg)}) begin
      failures++; $display("FAIL l3_use_bundle gap=%0d got=%b exp=%b", gap,
        {if3.ctl_valid, if3.addmov, if3.rd_q, if3.rd_from_ram, if3.rs_from_ram},
        {2'b11, urd, FWD & (urd == lreg), FWD & (urs == lreg)}); end
    repeat (4) tick();
  endtask

  task automatic test_lcg_back_to_back();
    int cyc = 0;
    int lastidx = 0;
    int lastcnt = 0;
    if1.instr = {OP_LCG, 3'b011, 6'd0}; if1.rd = 3'd2; if1.rs = 3'd5; if1.instr_valid = 1'b1;
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL lcg_ready0 got=%b exp=1", if1.instr_ready); end
    tick();
    if1.instr = {OP_LCG, 3'b010, 6'd0};
    while (if1.mul_busy === 1'b1 && cyc < 40) begin
      cyc++;
      checks++; if (if1.mul_start !== (cyc == 1)) begin failures++; $display("FAIL lcg_start c%0d got=%b exp=%b", cyc, if1.mul_start, cyc == 1); end
      checks++; if ({if1.mul_gp5, if1.mul_loop, if1.mul_msb} !== 3'b111) begin
        failures++; $display("FAIL lcg_held c%0d got=%b exp=111", cyc, {if1.mul_gp5, if1.mul_loop, if1.mul_msb}); end
      checks++; if (if1.instr_ready !== 1'b0) begin failures++; $display("FAIL lcg_busy_ready c%0d got=%b exp=0", cyc, if1.instr_ready); end
      if (cyc == 1) begin
        checks++; if (ctl1 !== 11'b11011000010 || if1.imm !== 16'h0001) begin
          failures++; $display("FAIL lcg_bundle got=%b/%h exp=11011000010/0001", ctl1, if1.imm); end
      end
      if (if1.mul_last === 1'b1) begin lastcnt++; lastidx = cyc; end
      tick();
    end
    checks++; if (cyc != 16) begin failures++; $display("FAIL lcg_busy_len got=%0d exp=16", cyc); end
    checks++; if (lastidx != 16 || lastcnt != 1) begin failures++; $display("FAIL lcg_last got=idx%0d/n%0d exp=idx16/n1", lastidx, lastcnt); end
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL lcg_ready_after got=%b exp=1", if1.instr_ready); end
    tick();
    if1.instr_valid = 1'b0;
    checks++; if ({if1.mul_start, if1.mul_busy, if1.mul_gp5, if1.mul_loop, if1.mul_msb} !== 5'b11110) begin
      failures++; $display("FAIL lcg2_start got=%b exp=11110", {if1.mul_start, if1.mul_busy, if1.mul_gp5, if1.mul_loop, if1.mul_msb}); end
  endtask

  task automatic test_reset_mid_mul();
    int bad = 0;
    repeat (4) tick();
    checks++; if (if1.mul_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", if1.mul_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all1 !== '0) begin failures++; $display("FAIL async_reset_out got=%h exp=0", all1); end
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", if1.instr_ready); end
    tick();
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (if1.mul_last !== 1'b0 || if1.mul_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL post_reset_mul got=%0d exp=0", bad); end
    checks++; if (if1.instr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", if1.instr_ready); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_fwd_l1();
    test_load_hazard_l3(1'b1, 3'd4, 3'd4, 3'd1, FWD ? 1 : 2);
    test_load_hazard_l3(1'b0, 3'd5, 3'd2, 3'd5, FWD ? 2 : 3);
    test_lcg_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
